tlul_lsu_host: RTL and testbench
================================

# tlul_lsu_host

Host-side TL-UL adapter that converts the core load/store unit's req/gnt/rvalid data interface into a TL-UL A/D channel pair. Its TL-UL output drives the LSU host port of `xbar_periph`. It tracks up to `MAX_REQS` outstanding transactions and returns responses to the core in order, registered by one cycle.

## Interface
- `MAX_REQS`, default 2: maximum outstanding A-channel requests; legal values are 1–4.
- `SRC_W`, default 2: width of the source ID used in `a_source`; requires 2^SRC_W ≥ MAX_REQS.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in 1: core requests a transaction.
- `gnt_o` out 1: request accepted this cycle.
- `addr_i` in 32: byte address.
- `we_i` in 1: 1 = store, 0 = load.
- `be_i` in 4: byte enables.
- `wdata_i` in 32: store data.
- `rvalid_o` out 1: response valid, one-cycle pulse per request.
- `rdata_o` out 32: load data.
- `err_o` out 1: response error; qualified by `rvalid_o`.
- `tl_o` out `tlul_pkg::tl_h2d_t`: TL-UL request to the crossbar.
- `tl_i` in `tlul_pkg::tl_d2h_t`: TL-UL response from the crossbar.
- `outstanding_o` out 3: current outstanding count, for debug and verification.

## Operation
- `full` = (outstanding == MAX_REQS).
- `tl_o.a_valid` = `req_i & ~full`.
- `gnt_o` = `tl_o.a_valid & tl_i.a_ready`. An A handshake is the same event as `gnt_o`.
- A-channel field mapping:
  - `a_address` = {addr_i[31:2], 2'b00}.
  - `a_size` = 2.
  - `a_param` = 0.
  - `a_mask` = `be_i`.
  - `a_data` = `wdata_i`.
  - `a_user` = 0.
- Opcode selection:
  - Load: Get (4).
  - Store with `be_i` = 4'hF: PutFullData (0).
  - Store with any other `be_i`: PutPartialData (1).
- Source ID: `a_source` = `src_q`. `src_q` increments on each A handshake and wraps from MAX_REQS-1 to 0.
- Expected-response FIFO: depth MAX_REQS, each entry {we, source}.
  - Push on A handshake.
  - Pop on an accepted D beat.
- `tl_o.d_ready` is tied to 1.
- A D beat is accepted only when `d_valid` is high and outstanding > 0.
  - When outstanding == 0, `d_valid` is discarded: no `rvalid_o`, the counter does not change (no underflow).
- Outstanding counter:
  - +1 on an A handshake.
  - −1 on an accepted D beat.
  - Unchanged when both occur in the same cycle.
  - The A handshake is already blocked when full, so the counter cannot exceed MAX_REQS.
- Response checks on each accepted D beat; `err_o` = 1 if any of the following holds:
  - `d_error` = 1.
  - `d_source` differs from the FIFO head source.
  - The opcode does not match the head: a read expects AccessAckData (1), a write expects AccessAck (0).
- `rdata_o` = `d_data` for a read head, and 0 for a write head or when `err_o` is set.
- Responses are returned in acceptance order. Out-of-order `d_source` is reported as an error, not reordered.
- Reset returns every register to zero: `src_q`, FIFO pointers, outstanding count, `rvalid_o`, `rdata_o`, `err_o`.
  - All in-flight transactions are abandoned.
  - Late D beats arriving after reset are discarded by the outstanding == 0 rule.

## Timing
- The A channel is combinational from `req_i`/`addr_i`; the request is issued in the same cycle.
- `gnt_o` is combinational on `tl_i.a_ready`.
- Response latency: `rvalid_o`, `rdata_o` and `err_o` are registered and assert in the cycle after the accepted D beat.
  - `rvalid_o` is high for exactly 1 cycle per beat.
  - `rdata_o` and `err_o` hold their values until the next `rvalid_o`.
- Back-to-back operation:
  - One A handshake and one D beat can complete in the same cycle.
  - Sustained throughput is 1 transaction per cycle when the fabric responds with zero wait.
- When full, a D beat in cycle N frees a slot in cycle N+1. `gnt_o` does not use the same-cycle freed slot (no combinational D→A path).
- Reset values of outputs:
  - `gnt_o` = 0 and `tl_o.a_valid` = 0 while `rst_ni` = 0.
  - `tl_o.d_ready` = 1 while `rst_ni` = 0.
  - `rvalid_o`, `rdata_o`, `err_o` and `outstanding_o` = 0.

## Test plan
- Single load to 0x1000_0004 with be=F; slave returns AccessAckData with data 0xDEADBEEF one cycle later:
  - `a_opcode`=4, `gnt_o` in the request cycle.
  - `rvalid_o`=1 with `rdata_o`=0xDEADBEEF and `err_o`=0 one cycle after the D beat.
- Store to 0x1000_0002 with be=4'b1100 and wdata 0xA5A5_0000:
  - `a_opcode`=1, `a_address`=0x1000_0000, `a_mask`=C.
  - AccessAck response → `rvalid_o` with `rdata_o`=0 and `err_o`=0.
  - A store with be=F drives `a_opcode`=0.
- MAX_REQS=2, `a_ready`=1, D channel held idle, 3 back-to-back requests:
  - Grants in cycles 0 and 1, sources 0 and 1.
  - Third request: `a_valid`=0 and `gnt_o`=0 until a D beat; it is granted with source 0 in the cycle after that beat.
- Error cases:
  - D beat with `d_error`=1 → `err_o`=1, `rdata_o`=0.
  - Read answered with AccessAck → `err_o`=1.
  - `d_source`=1 while the FIFO head is 0 → `err_o`=1.
- Spurious `d_valid` with outstanding=0 → no `rvalid_o`; `outstanding_o` stays 0.
- Reset asserted with 2 transactions outstanding, then late D beats after release:
  - All outputs read 0 during reset.
  - Late beats are discarded; the next request is issued with source 0.

Source files
------------

// File: rtl/tlul_lsu_host.sv
// -----------------------------------------------------------------------------
// tlul_pkg : minimal TL-UL type definitions for the host adapter
// tlul_lsu_host : converts the core LSU req/gnt/rvalid interface into a TL-UL
//                 A/D channel pair. It tracks up to MAX_REQS outstanding
//                 requests and returns responses in order, registered by one
//                 cycle.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i / gnt_o      core request / same-cycle grant (= A handshake)
//   addr_i, we_i, be_i, wdata_i   request attributes
//   rvalid_o, rdata_o, err_o      registered response to the core
//   tl_o / tl_i        TL-UL host-to-device / device-to-host bundles
//   outstanding_o      number of requests currently in flight
// -----------------------------------------------------------------------------
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_lsu_host #(
    parameter int unsigned MAX_REQS = 2,
    parameter int unsigned SRC_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic [2:0]        outstanding_o
);

    localparam int unsigned      PTR_W    = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_REQS - 1);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(MAX_REQS - 1);
    localparam logic [2:0]       CNT_MAX  = 3'(MAX_REQS);

    logic [SRC_W-1:0] src_q, src_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    // Expected-response FIFO, one {we, source} entry per in-flight request.
    logic             fifo_we_q  [MAX_REQS];
    logic [SRC_W-1:0] fifo_src_q [MAX_REQS];

    logic             full;
    logic             a_valid;
    logic             a_hs;
    logic             d_acc;
    logic             head_we;
    logic [SRC_W-1:0] head_src;
    logic             resp_err;
    logic             unused_d;

    // Only the counter gates the A channel, so a D beat freeing a slot takes
    // effect one cycle later; there is no combinational D->A path. Gating with
    // rst_ni keeps the request quiet while reset is held.
    assign full    = (cnt_q == CNT_MAX);
    assign a_valid = req_i & ~full & rst_ni;
    assign a_hs    = a_valid & tl_i.a_ready;
    assign gnt_o   = a_hs;

    // Beats with nothing outstanding (spurious or from before a reset) are
    // dropped here so the counter can never underflow.
    assign d_acc    = tl_i.d_valid & (cnt_q != 3'd0);
    assign head_we  = fifo_we_q[rptr_q];
    assign head_src = fifo_src_q[rptr_q];

    assign resp_err = tl_i.d_error
                    | (tl_i.d_source != 8'(head_src))
                    | (head_we ? (tl_i.d_opcode != tlul_pkg::ACCESS_ACK)
                               : (tl_i.d_opcode != tlul_pkg::ACCESS_ACK_DATA));

    assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = !we_i          ? tlul_pkg::GET :
                         (be_i == 4'hF) ? tlul_pkg::PUT_FULL_DATA :
                                          tlul_pkg::PUT_PARTIAL_DATA;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = 8'(src_q);
        tl_o.a_address = {addr_i[31:2], 2'b00};
        tl_o.a_mask    = be_i;
        tl_o.a_data    = wdata_i;
        tl_o.a_user    = '0;
        tl_o.d_ready   = 1'b1;
    end

    always_comb begin
        src_d    = src_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        rvalid_d = d_acc;
        rdata_d  = rdata_q;
        err_d    = err_q;

        if (a_hs) begin
            src_d  = (src_q == SRC_LAST) ? '0 : src_q + 1'b1;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (d_acc) begin
            rptr_d  = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            err_d   = resp_err;
            rdata_d = (resp_err || head_we) ? 32'd0 : tl_i.d_data;
        end

        unique case ({a_hs, d_acc})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            src_q    <= src_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    for (genvar gi = 0; gi < int'(MAX_REQS); gi++) begin : g_fifo
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fifo_we_q[gi]  <= 1'b0;
                fifo_src_q[gi] <= '0;
            end else if (a_hs && (wptr_q == PTR_W'(gi))) begin
                fifo_we_q[gi]  <= we_i;
                fifo_src_q[gi] <= src_q;
            end
        end
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_tlul_lsu_host.sv
// -----------------------------------------------------------------------------
// Testbench for tlul_lsu_host (MAX_REQS = 2). Directed scenarios from the
// adapter's behaviour followed by a randomized run checked against a
// queue-based model of in-flight requests.
// -----------------------------------------------------------------------------
module tb_tlul_lsu_host;

    localparam int MAX = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req;
    logic              gnt;
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [2:0]        outstanding;
    tlul_pkg::tl_h2d_t tl_h2d;
    tlul_pkg::tl_d2h_t tl_d2h;

    int vec_cnt = 0;
    int err_cnt = 0;

    tlul_lsu_host #(.MAX_REQS(MAX), .SRC_W(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .tl_o         (tl_h2d),
        .tl_i         (tl_d2h),
        .outstanding_o(outstanding)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req   = 1'b0;
        addr  = '0;
        we    = 1'b0;
        be    = 4'h0;
        wdata = '0;
        tl_d2h = '0;
        tl_d2h.a_ready = 1'b1;
    endtask

    task automatic set_req(input logic r, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        req = r; addr = a; we = w; be = b; wdata = d;
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [7:0] src,
                         input logic [31:0] d, input logic e);
        tl_d2h.d_valid  = v;
        tl_d2h.d_opcode = op;
        tl_d2h.d_source = src;
        tl_d2h.d_data   = d;
        tl_d2h.d_error  = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        req = 1'b1;
        set_d(1'b1, 3'd1, 8'd0, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_valid, tl_h2d.d_ready, rvalid, rdata, err, outstanding} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL reset_outputs: got gnt=%b av=%b dr=%b rv=%b rd=%h e=%b out=%0d expected 0 0 1 0 0 0 0",
                     gnt, tl_h2d.a_valid, tl_h2d.d_ready, rvalid, rdata, err, outstanding);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        @(negedge clk);
        set_req(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'd0);
        #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_valid, tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_source, tl_h2d.a_size} !==
            {1'b1, 1'b1, 3'd4, 32'h1000_0004, 8'd0, 2'd2}) begin
            err_cnt++;
            $display("FAIL load_request: got gnt=%b av=%b op=%0d addr=%h src=%0d size=%0d expected 1 1 4 10000004 0 2",
                     gnt, tl_h2d.a_valid, tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_source, tl_h2d.a_size);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (outstanding !== 3'd1) begin
            err_cnt++;
            $display("FAIL load_outstanding: got %0d expected 1", outstanding);
        end
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0);
        #1;
        vec_cnt++;
        if (rvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_early_rvalid: got %b expected 0", rvalid);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata, err, outstanding} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL load_response: got rv=%b rd=%h e=%b out=%0d expected 1 deadbeef 0 0",
                     rvalid, rdata, err, outstanding);
        end
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            err_cnt++;
            $display("FAIL load_hold: got rv=%b rd=%h expected 0 deadbeef", rvalid, rdata);
        end
    endtask

    // Source IDs continue from the previous test: one grant so far -> source 1.
    task automatic test_store();
        @(negedge clk);
        set_req(1'b1, 32'h1000_0002, 1'b1, 4'b1100, 32'hA5A5_0000);
        #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_mask, tl_h2d.a_data, tl_h2d.a_source} !==
            {1'b1, 3'd1, 32'h1000_0000, 4'hC, 32'hA5A5_0000, 8'd1}) begin
            err_cnt++;
            $display("FAIL partial_store_req: got gnt=%b op=%0d addr=%h mask=%h data=%h src=%0d expected 1 1 10000000 c a5a50000 1",
                     gnt, tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_mask, tl_h2d.a_data, tl_h2d.a_source);
        end
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd0, 8'd1, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata, err, outstanding} !== {1'b1, 32'd0, 1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL store_response: got rv=%b rd=%h e=%b out=%0d expected 1 0 0 0",
                     rvalid, rdata, err, outstanding);
        end
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        set_req(1'b1, 32'h2000_0008, 1'b1, 4'hF, 32'h0BAD_F00D);
        #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_opcode, tl_h2d.a_source} !== {1'b1, 3'd0, 8'd0}) begin
            err_cnt++;
            $display("FAIL full_store_req: got gnt=%b op=%0d src=%0d expected 1 0 0",
                     gnt, tl_h2d.a_opcode, tl_h2d.a_source);
        end
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd0, 8'd0, 32'd0, 1'b0);
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
    endtask

    task automatic test_full();
        logic       exp_gnt;
        logic [7:0] exp_src;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_req(1'b1, 32'h3000_0000 + 32'(c * 4), 1'b0, 4'hF, '0);
            if (c == 4) set_d(1'b1, 3'd1, 8'd0, 32'h0000_00AA, 1'b0);
            else        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
            exp_gnt = (c < 2) || (c == 5);
            exp_src = (c == 1) ? 8'd1 : 8'd0;
            #1;
            vec_cnt++;
            if ({gnt, tl_h2d.a_valid} !== {exp_gnt, exp_gnt} ||
                (exp_gnt && tl_h2d.a_source !== exp_src)) begin
                err_cnt++;
                $display("FAIL full_grant_c%0d: got gnt=%b av=%b src=%0d expected %b %b %0d",
                         c, gnt, tl_h2d.a_valid, tl_h2d.a_source, exp_gnt, exp_gnt, exp_src);
            end
        end
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd1, 32'h0000_00BB, 1'b0);
        #1;
        vec_cnt++;
        if (outstanding !== 3'd2) begin
            err_cnt++;
            $display("FAIL full_outstanding: got %0d expected 2", outstanding);
        end
        @(negedge clk);
        set_d(1'b1, 3'd1, 8'd0, 32'h0000_00CC, 1'b0);
        #1;
        vec_cnt++;
        if ({rvalid, rdata, err} !== {1'b1, 32'h0000_00BB, 1'b0}) begin
            err_cnt++;
            $display("FAIL full_drain1: got rv=%b rd=%h e=%b expected 1 bb 0", rvalid, rdata, err);
        end
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        #1;
        vec_cnt++;
        if ({rvalid, rdata, err, outstanding} !== {1'b1, 32'h0000_00CC, 1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL full_drain2: got rv=%b rd=%h e=%b out=%0d expected 1 cc 0 0",
                     rvalid, rdata, err, outstanding);
        end
    endtask

    task automatic test_errors();
        do_reset();
        // d_error on a read: source 0
        @(negedge clk); set_req(1'b1, 32'h4000_0000, 1'b0, 4'hF, '0);
        @(negedge clk); set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd0, 32'h1111_1111, 1'b1);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata, err} !== {1'b1, 32'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL err_d_error: got rv=%b rd=%h e=%b expected 1 0 1", rvalid, rdata, err);
        end
        // read answered with AccessAck: source 1
        @(negedge clk); set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        set_req(1'b1, 32'h4000_0004, 1'b0, 4'hF, '0);
        @(negedge clk); set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd0, 8'd1, 32'h2222_2222, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata, err} !== {1'b1, 32'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL err_opcode: got rv=%b rd=%h e=%b expected 1 0 1", rvalid, rdata, err);
        end
        // two reads (sources 0, 1), answered in swapped source order
        @(negedge clk); set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        set_req(1'b1, 32'h4000_0008, 1'b0, 4'hF, '0);
        @(negedge clk);
        @(negedge clk); set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd1, 32'h3333_3333, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, rdata, err} !== {1'b1, 32'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL err_source1: got rv=%b rd=%h e=%b expected 1 0 1", rvalid, rdata, err);
        end
        @(negedge clk); set_d(1'b1, 3'd1, 8'd0, 32'h4444_4444, 1'b0);
        @(posedge clk); #1;
        vec_cnt++;
        if ({rvalid, err, outstanding} !== {1'b1, 1'b1, 3'd0}) begin
            err_cnt++;
            $display("FAIL err_source2: got rv=%b e=%b out=%0d expected 1 1 0", rvalid, err, outstanding);
        end
        @(negedge clk); set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_d(1'b1, 3'd1, 8'(c), 32'hCAFE_0000 + 32'(c), 1'b0);
            @(posedge clk); #1;
            vec_cnt++;
            if ({rvalid, outstanding} !== {1'b0, 3'd0}) begin
                err_cnt++;
                $display("FAIL spurious_c%0d: got rv=%b out=%0d expected 0 0", c, rvalid, outstanding);
            end
        end
        @(negedge clk); set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        @(negedge clk); set_req(1'b1, 32'h5000_0000, 1'b0, 4'hF, '0);
        @(negedge clk); set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd0, 32'h1234_5678, 1'b0);
        @(negedge clk); set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        set_req(1'b1, 32'h5000_0004, 1'b0, 4'hF, '0);
        @(negedge clk);
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        #1;
        vec_cnt++;
        if ({outstanding, rdata} !== {3'd2, 32'h1234_5678}) begin
            err_cnt++;
            $display("FAIL inflight_setup: got out=%0d rd=%h expected 2 12345678", outstanding, rdata);
        end
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b1;
        #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_valid, tl_h2d.d_ready, rvalid, rdata, err, outstanding} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL inflight_reset: got gnt=%b av=%b dr=%b rv=%b rd=%h e=%b out=%0d expected 0 0 1 0 0 0 0",
                     gnt, tl_h2d.a_valid, tl_h2d.d_ready, rvalid, rdata, err, outstanding);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_d(1'b1, 3'd1, 8'(c + 1), 32'h7777_0000, 1'b0);
            @(posedge clk); #1;
            vec_cnt++;
            if ({rvalid, outstanding} !== {1'b0, 3'd0}) begin
                err_cnt++;
                $display("FAIL late_beat_c%0d: got rv=%b out=%0d expected 0 0", c, rvalid, outstanding);
            end
        end
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
        set_req(1'b1, 32'h5000_0010, 1'b0, 4'hF, '0);
        #1;
        vec_cnt++;
        if ({gnt, tl_h2d.a_source} !== {1'b1, 8'd0}) begin
            err_cnt++;
            $display("FAIL post_reset_req: got gnt=%b src=%0d expected 1 0", gnt, tl_h2d.a_source);
        end
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, 4'h0, '0);
        set_d(1'b1, 3'd1, 8'd0, 32'd0, 1'b0);
        @(negedge clk);
        set_d(1'b0, 3'd0, 8'd0, 32'd0, 1'b0);
    endtask

    typedef struct {
        bit we;
        int src;
    } ent_t;

    task automatic test_random();
        ent_t        exp_q[$];
        ent_t        head;
        int          m_src;
        int          k;
        logic        exp_avalid, exp_gnt, exp_rvalid, exp_err, e;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_op;
        do_reset();
        m_src = 0;
        exp_rdata = '0;
        exp_err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 3) != 0);
            addr  = $urandom;
            we    = 1'($urandom_range(0, 1));
            be    = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            wdata = $urandom;
            tl_d2h = '0;
            tl_d2h.a_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                head = exp_q[0];
                set_d(1'b1, head.we ? 3'd0 : 3'd1, 8'(head.src), $urandom, 1'b0);
                k = $urandom_range(0, 9);
                if (k == 0) tl_d2h.d_error  = 1'b1;
                if (k == 1) tl_d2h.d_opcode = head.we ? 3'd1 : 3'd0;
                if (k == 2) tl_d2h.d_source = 8'(head.src ^ 1);
            end else if (exp_q.size() == 0 && $urandom_range(0, 7) == 0) begin
                set_d(1'b1, 3'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom, 1'b0);
            end
            #1;
            exp_avalid = req && (exp_q.size() < MAX);
            exp_gnt    = exp_avalid && tl_d2h.a_ready;
            exp_op     = !we ? 3'd4 : (be == 4'hF) ? 3'd0 : 3'd1;
            vec_cnt++;
            if ({tl_h2d.a_valid, gnt} !== {exp_avalid, exp_gnt} ||
                (exp_avalid && ({tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_mask, tl_h2d.a_data,
                                 tl_h2d.a_source, tl_h2d.a_size, tl_h2d.a_param} !==
                                {exp_op, addr & 32'hFFFF_FFFC, be, wdata, 8'(m_src), 2'd2, 3'd0}))) begin
                err_cnt++;
                $display("FAIL rand_a_n%0d: got av=%b gnt=%b op=%0d addr=%h src=%0d expected %b %b %0d %h %0d",
                         n, tl_h2d.a_valid, gnt, tl_h2d.a_opcode, tl_h2d.a_address, tl_h2d.a_source,
                         exp_avalid, exp_gnt, exp_op, addr & 32'hFFFF_FFFC, m_src);
            end
            exp_rvalid = 1'b0;
            if (tl_d2h.d_valid && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                e = tl_d2h.d_error || (int'(tl_d2h.d_source) != head.src) ||
                    (tl_d2h.d_opcode != (head.we ? 3'd0 : 3'd1));
                exp_rvalid = 1'b1;
                exp_err    = e;
                exp_rdata  = (e || head.we) ? 32'd0 : tl_d2h.d_data;
            end
            if (exp_gnt) begin
                exp_q.push_back('{we: we, src: m_src});
                m_src = (m_src + 1) % MAX;
            end
            @(posedge clk); #1;
            vec_cnt++;
            if ({rvalid, rdata, err, outstanding} !== {exp_rvalid, exp_rdata, exp_err, 3'(exp_q.size())}) begin
                err_cnt++;
                $display("FAIL rand_d_n%0d: got rv=%b rd=%h e=%b out=%0d expected %b %h %b %0d",
                         n, rvalid, rdata, err, outstanding, exp_rvalid, exp_rdata, exp_err, exp_q.size());
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_load();
        test_store();
        test_full();
        test_errors();
        test_spurious();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
